// File: rtl/tick_seq_pkg.sv
// Shared types and constants for the tick-timed pulse burst sequencer.
package tick_seq_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_HIGH,
        ST_LOW,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/div_clk_sync.sv
// Brings div_clk into the clk_in domain and emits a registered one-cycle tick per rising edge.
module div_clk_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic i_div_clk,
    output logic o_tick
);

    localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_tick;
    logic [WARM_W-1:0]      r_warm;
    logic                   w_warm_done;
    logic                   w_rise;

    assign w_warm_done = (r_warm == WARM_W'(WARM_CYCLES));
    assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_tick      = r_tick;

    // Warm-up gate hides the apparent edge when div_clk is already high at reset release.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_tick <= 1'b0;
            r_warm <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_div_clk};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_tick <= w_rise & w_warm_done;
            if (!w_warm_done) begin
                r_warm <= r_warm + WARM_W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_pulse_sequencer.sv
// Programmable pulse burst generator timed in synchronized div_clk ticks: start delay,
// then num_pulses pulses of high_ticks width separated by low_ticks gaps.
module tick_pulse_sequencer
    import tick_seq_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             i_div_clk,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_delay_ticks,
    input  logic [CNT_W-1:0] i_num_pulses,
    input  logic [CNT_W-1:0] i_high_ticks,
    input  logic [CNT_W-1:0] i_low_ticks,
    output logic             o_tick,
    output logic             o_pulse_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pulse_count
);

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0] r_num, w_num_next;
    logic [CNT_W-1:0] r_high, w_high_next;
    logic [CNT_W-1:0] r_low, w_low_next;
    logic [CNT_W-1:0] r_pcount, w_pcount_next;
    logic [CNT_W-1:0] w_pcount_inc;
    logic [CNT_W-1:0] w_high_in;
    logic [CNT_W-1:0] w_low_in;
    logic             r_pulse;
    logic             w_tick;
    logic             w_last;

    div_clk_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in    (clk_in),
        .reset     (reset),
        .i_div_clk (i_div_clk),
        .o_tick    (w_tick)
    );

    // Zero widths behave as one tick.
    assign w_high_in    = (i_high_ticks == '0) ? CNT_W'(1) : i_high_ticks;
    assign w_low_in     = (i_low_ticks == '0) ? CNT_W'(1) : i_low_ticks;
    assign w_pcount_inc = r_pcount + CNT_W'(1);
    assign w_last       = (r_cnt == CNT_W'(1));

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_num_next    = r_num;
        w_high_next   = r_high;
        w_low_next    = r_low;
        w_pcount_next = r_pcount;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_num_next    = i_num_pulses;
                    w_high_next   = w_high_in;
                    w_low_next    = w_low_in;
                    w_pcount_next = '0;
                    if (i_num_pulses == '0) begin
                        w_state_next = ST_FINISH;
                    end else if (i_delay_ticks == '0) begin
                        w_state_next = ST_HIGH;
                        w_cnt_next   = w_high_in;
                    end else begin
                        w_state_next = ST_DELAY;
                        w_cnt_next   = i_delay_ticks;
                    end
                end
            end
            ST_DELAY, ST_LOW: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (w_last) begin
                        w_state_next = ST_HIGH;
                        w_cnt_next   = r_high;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
            end
            ST_HIGH: begin
                if (i_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (w_last) begin
                        w_pcount_next = w_pcount_inc;
                        if (w_pcount_inc == r_num) begin
                            w_state_next = ST_FINISH;
                        end else begin
                            w_state_next = ST_LOW;
                            w_cnt_next   = r_low;
                        end
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // pulse_out is registered from the next state so it tracks HIGH without a decode glitch.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_num    <= '0;
            r_high   <= '0;
            r_low    <= '0;
            r_pcount <= '0;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_num    <= w_num_next;
            r_high   <= w_high_next;
            r_low    <= w_low_next;
            r_pcount <= w_pcount_next;
            r_pulse  <= (w_state_next == ST_HIGH);
        end
    end

    assign o_tick        = w_tick;
    assign o_pulse_out   = r_pulse;
    assign o_busy        = (r_state == ST_DELAY) || (r_state == ST_HIGH) || (r_state == ST_LOW);
    assign o_done        = (r_state == ST_FINISH);
    assign o_pulse_count = r_pcount;

endmodule

// File: tb/tb_tick_pulse_sequencer.sv
// Self-checking bench: burst-schedule reference model, tick latency tracker,
// table-driven bursts and hand-written corner sequences.
module tb_tick_pulse_sequencer;

    localparam int unsigned CNT_W = 16;

    logic             clk_in  = 1'b0;
    logic             reset   = 1'b1;
    logic             div_clk = 1'b0;
    logic             start   = 1'b0;
    logic             abort   = 1'b0;
    logic [CNT_W-1:0] delay_t = '0;
    logic [CNT_W-1:0] num_p   = '0;
    logic [CNT_W-1:0] high_t  = '0;
    logic [CNT_W-1:0] low_t   = '0;
    logic             tick;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulse_count;

    int errors = 0;
    int checks = 0;

    logic div_run  = 1'b0;
    logic div_idle = 1'b0;
    int   div_half = 4;

    tick_pulse_sequencer #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .i_div_clk     (div_clk),
        .i_start       (start),
        .i_abort       (abort),
        .i_delay_ticks (delay_t),
        .i_num_pulses  (num_p),
        .i_high_ticks  (high_t),
        .i_low_ticks   (low_t),
        .o_tick        (tick),
        .o_pulse_out   (pulse_out),
        .o_busy        (busy),
        .o_done        (done),
        .o_pulse_count (pulse_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Divided clock source, changed just after the rising edge.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk_in);
            #2;
            if (div_run) begin
                cnt++;
                if (cnt >= div_half) begin
                    cnt = 0;
                    div_clk = ~div_clk;
                end
            end else begin
                cnt = 0;
                div_clk = div_idle;
            end
        end
    end

    // Reference model: a burst is a schedule over k = ticks consumed since start.
    typedef enum {M_IDLE, M_ACT, M_FIN} mph_e;
    mph_e   m_ph = M_IDLE;
    longint m_k = 0, m_d = 0, m_n = 0, m_h = 1, m_l = 1, m_cnt = 0;

    function automatic longint m_pulses_done(input longint k);
        longint q, c;
        if (k < m_d) return 0;
        q = k - m_d;
        if (q < m_h) return 0;
        c = (q - m_h) / (m_h + m_l) + 1;
        return (c > m_n) ? m_n : c;
    endfunction

    function automatic bit m_pulse_hi(input longint k);
        if (k < m_d) return 1'b0;
        return ((k - m_d) % (m_h + m_l)) < m_h;
    endfunction

    initial begin
        longint cyc;
        longint rise_at;
        longint rise_q[$];
        logic   prev_div;
        cyc = 0;
        prev_div = 1'b0;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (reset) begin
                check("rst_tick", longint'(tick), 0);
                check("rst_pulse_out", longint'(pulse_out), 0);
                check("rst_busy", longint'(busy), 0);
                check("rst_done", longint'(done), 0);
                check("rst_pulse_count", longint'(pulse_count), 0);
                m_ph = M_IDLE;
                m_cnt = 0;
                rise_q.delete();
                prev_div = div_clk;
            end else begin
                if (div_clk && !prev_div) rise_q.push_back(cyc);
                prev_div = div_clk;
                if (tick) begin
                    check("tick_has_source_edge", longint'(rise_q.size() > 0), 1);
                    if (rise_q.size() > 0) begin
                        rise_at = rise_q.pop_front();
                        check("tick_latency_in_window",
                              longint'(cyc - rise_at >= 2 && cyc - rise_at <= 4), 1);
                    end
                end
                if (rise_q.size() > 0) begin
                    check("tick_not_missing", longint'(cyc - rise_q[0] <= 4), 1);
                    if (cyc - rise_q[0] > 4) void'(rise_q.pop_front());
                end
                check("model_busy", longint'(busy), longint'(m_ph == M_ACT));
                check("model_done", longint'(done), longint'(m_ph == M_FIN));
                check("model_pulse_out", longint'(pulse_out),
                      longint'(m_ph == M_ACT && m_pulse_hi(m_k)));
                check("model_pulse_count", longint'(pulse_count),
                      (m_ph == M_ACT) ? m_pulses_done(m_k) : m_cnt);
                case (m_ph)
                    M_IDLE: begin
                        if (start && !abort) begin
                            m_d   = longint'(delay_t);
                            m_n   = longint'(num_p);
                            m_h   = (high_t == '0) ? 1 : longint'(high_t);
                            m_l   = (low_t == '0) ? 1 : longint'(low_t);
                            m_k   = 0;
                            m_cnt = 0;
                            m_ph  = (m_n == 0) ? M_FIN : M_ACT;
                        end
                    end
                    M_ACT: begin
                        if (abort) begin
                            m_cnt = m_pulses_done(m_k);
                            m_ph  = M_IDLE;
                        end else if (tick) begin
                            m_k++;
                            if (m_k >= m_d && (m_k - m_d) >= (m_n - 1) * (m_h + m_l) + m_h) begin
                                m_cnt = m_n;
                                m_ph  = M_FIN;
                            end
                        end
                    end
                    default: m_ph = M_IDLE;
                endcase
            end
        end
    end

    typedef struct {
        int delay;
        int num;
        int high;
        int low;
        int exp_ticks;
        int exp_width;
        int exp_gap;
        int exp_rise1;
        int exp_busy1;
        int exp_done1;
    } row_t;

    row_t rows[6];

    task automatic run_row(input row_t r, input int idx);
        int   ticks_busy, pulses, dones, width, gap;
        logic prev_p;
        bit   seen_done;
        ticks_busy = 0; pulses = 0; dones = 0; width = 0; gap = 0;
        prev_p = 1'b0; seen_done = 1'b0;
        @(posedge clk_in); #2;
        delay_t = CNT_W'(r.delay);
        num_p   = CNT_W'(r.num);
        high_t  = CNT_W'(r.high);
        low_t   = CNT_W'(r.low);
        start   = 1'b1;
        @(posedge clk_in); #2;
        start = 1'b0;
        @(negedge clk_in);
        check($sformatf("row%0d_first_pulse", idx), longint'(pulse_out), r.exp_rise1);
        check($sformatf("row%0d_first_busy", idx), longint'(busy), r.exp_busy1);
        check($sformatf("row%0d_first_done", idx), longint'(done), r.exp_done1);
        for (int c = 0; c < 1500 && !seen_done; c++) begin
            if (c > 0) @(negedge clk_in);
            if (busy && tick) ticks_busy++;
            if (pulse_out) begin
                if (!prev_p) begin
                    if (pulses > 0) check($sformatf("row%0d_gap", idx), gap, r.exp_gap);
                    pulses++;
                    width = 0;
                end
                width++;
            end else begin
                if (prev_p && (pulses > 1 || r.exp_rise1 == 0))
                    check($sformatf("row%0d_width", idx), width, r.exp_width);
                if (prev_p) gap = 0;
                gap++;
            end
            prev_p = pulse_out;
            if (done) begin
                dones++;
                seen_done = 1'b1;
                check($sformatf("row%0d_busy_at_done", idx), longint'(busy), 0);
            end
        end
        check($sformatf("row%0d_done_seen", idx), longint'(seen_done), 1);
        check($sformatf("row%0d_ticks_busy", idx), ticks_busy, r.exp_ticks);
        check($sformatf("row%0d_pulses", idx), pulses, r.num);
        check($sformatf("row%0d_pulse_count", idx), longint'(pulse_count), r.num);
        repeat (4) begin
            @(negedge clk_in);
            if (done) dones++;
        end
        check($sformatf("row%0d_done_strobes", idx), dones, 1);
    endtask

    initial begin
        int   cnt;
        bit   seen;
        logic prev;
        logic any;
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        bit   seen;
        logic prev;
        logic any;

        //          d  n  h  l  ticks width gap rise1 busy1 done1
        rows[0] = '{2, 3, 1, 2,  9,    8,   16,  0,    1,    0};
        rows[1] = '{0, 2, 0, 0,  3,    8,    8,  1,    1,    0};
        rows[2] = '{1, 1, 3, 5,  4,   24,    0,  0,    1,    0};
        rows[3] = '{0, 0, 2, 2,  0,    0,    0,  0,    0,    1};
        rows[4] = '{3, 2, 2, 1,  8,   16,    8,  0,    1,    0};
        rows[5] = '{0, 3, 2, 3, 12,   16,   24,  1,    1,    0};

        repeat (5) @(posedge clk_in);
        #2;
        reset = 1'b0;
        repeat (10) @(posedge clk_in);
        #2;
        div_half = 4;
        div_run  = 1'b1;
        repeat (20) @(posedge clk_in);

        for (int i = 0; i < 6; i++) run_row(rows[i], i);

        // Abort during the second HIGH of a five-pulse burst.
        @(posedge clk_in); #2;
        delay_t = 16'd1; num_p = 16'd5; high_t = 16'd3; low_t = 16'd2; start = 1'b1;
        @(posedge clk_in); #2;
        start = 1'b0;
        for (int c = 0; c < 1000 && !(pulse_out && pulse_count == 16'd1); c++) @(negedge clk_in);
        check("abort_reached_second_high", longint'(pulse_out && pulse_count == 16'd1), 1);
        @(posedge clk_in); #2;
        abort = 1'b1;
        @(posedge clk_in); #2;
        abort = 1'b0;
        @(negedge clk_in);
        check("abort_pulse_out", longint'(pulse_out), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_pulse_count", longint'(pulse_count), 1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (done || busy) cnt++;
        end
        check("abort_no_done_or_busy", cnt, 0);

        // start held through the burst and FINISH with config churn.
        @(posedge clk_in); #2;
        delay_t = 16'd1; num_p = 16'd2; high_t = 16'd1; low_t = 16'd1; start = 1'b1;
        @(posedge clk_in); #2;
        delay_t = 16'd3; num_p = 16'd7; high_t = 16'd5; low_t = 16'd4;
        cnt = 0; seen = 1'b0; prev = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk_in);
            if (pulse_out && !prev) cnt++;
            prev = pulse_out;
            if (done) seen = 1'b1;
        end
        check("coll_done_seen", longint'(seen), 1);
        check("coll_pulses", cnt, 2);
        check("coll_pulse_count", longint'(pulse_count), 2);
        @(posedge clk_in); #2;
        start = 1'b0;
        any = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            any = any | busy | done;
        end
        check("coll_finish_start_ignored", longint'(any), 0);

        // start together with abort in IDLE.
        @(posedge clk_in); #2;
        delay_t = 16'd0; num_p = 16'd1; high_t = 16'd1; low_t = 16'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk_in); #2;
        start = 1'b0; abort = 1'b0;
        any = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            any = any | busy | done | pulse_out;
        end
        check("start_abort_stays_idle", longint'(any), 0);

        // div_clk held high through reset release must not tick.
        @(posedge clk_in); #2;
        div_run = 1'b0; div_idle = 1'b1;
        repeat (8) @(posedge clk_in);
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        reset = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk_in);
            if (tick) cnt++;
        end
        check("warmup_no_false_tick", cnt, 0);
        @(posedge clk_in); #2;
        div_run = 1'b1;
        repeat (20) @(posedge clk_in);

        // Asynchronous reset during HIGH, then a clean restart.
        @(posedge clk_in); #2;
        delay_t = 16'd0; num_p = 16'd3; high_t = 16'd4; low_t = 16'd1; start = 1'b1;
        @(posedge clk_in); #2;
        start = 1'b0;
        for (int c = 0; c < 1000 && !(pulse_out && pulse_count == 16'd1); c++) @(negedge clk_in);
        check("rst_mid_reached_high", longint'(pulse_out && pulse_count == 16'd1), 1);
        @(posedge clk_in); #3;
        reset = 1'b1;
        div_run = 1'b0; div_idle = 1'b0;
        #1;
        check("rst_mid_pulse_out", longint'(pulse_out), 0);
        check("rst_mid_busy", longint'(busy), 0);
        check("rst_mid_done", longint'(done), 0);
        check("rst_mid_tick", longint'(tick), 0);
        check("rst_mid_pulse_count", longint'(pulse_count), 0);
        repeat (3) @(posedge clk_in);
        #2;
        reset = 1'b0;
        repeat (12) @(posedge clk_in);
        #2;
        div_run = 1'b1;
        repeat (20) @(posedge clk_in);
        run_row(rows[0], 10);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk_in); #2;
            if (c % 300 == 0) div_half = int'($urandom_range(2, 5));
            start   = ($urandom_range(0, 7) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            delay_t = CNT_W'($urandom_range(0, 3));
            num_p   = CNT_W'($urandom_range(0, 4));
            high_t  = CNT_W'($urandom_range(0, 3));
            low_t   = CNT_W'($urandom_range(0, 3));
        end
        @(posedge clk_in); #2;
        start = 1'b0;
        abort = 1'b0;
        repeat (500) @(posedge clk_in);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
